// File: rtl/bp_me_xbar_burst_rr.sv
// bp_me_xbar_burst_rr
// N-source x M-sink crossbar for BedRock Burst messages (header plus optional
// data beats). Each sink owns an arbiter and a small lock FSM so bursts to
// different sinks run concurrently. A source that has won a sink with a data
// burst is marked busy and hidden from every other sink until its last beat.
//
// Ports
//   clk_i, reset_n_i            clock, asynchronous active-low reset
//   msg_header_i/_v_i/_ready_and_o, msg_has_data_i, msg_dst_i
//                               per-source header channel + destination sink
//   msg_data_i/_v_i/_ready_and_o, msg_last_i
//                               per-source data beat channel
//   msg_header_o/_v_o/_ready_and_i, msg_has_data_o
//                               per-sink header channel
//   msg_data_o/_v_o/_ready_and_i, msg_last_o
//                               per-sink data beat channel
//   burst_overflow_o            per-sink sticky flag: a burst exceeded max_beats_p
module bp_me_xbar_burst_rr #(
    parameter int num_source_p   = 2,
    parameter int num_sink_p     = 2,
    parameter int header_width_p = 64,
    parameter int data_width_p   = 64,
    parameter int max_beats_p    = 8,
    parameter int rr_p           = 1,
    localparam int lg_num_sink_lp = (num_sink_p > 1) ? $clog2(num_sink_p) : 1
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic [num_source_p*header_width_p-1:0] msg_header_i,
    input  logic [num_source_p-1:0]                msg_header_v_i,
    output logic [num_source_p-1:0]                msg_header_ready_and_o,
    input  logic [num_source_p-1:0]                msg_has_data_i,
    input  logic [num_source_p*lg_num_sink_lp-1:0] msg_dst_i,
    input  logic [num_source_p*data_width_p-1:0]   msg_data_i,
    input  logic [num_source_p-1:0]                msg_data_v_i,
    output logic [num_source_p-1:0]                msg_data_ready_and_o,
    input  logic [num_source_p-1:0]                msg_last_i,
    output logic [num_sink_p*header_width_p-1:0]   msg_header_o,
    output logic [num_sink_p-1:0]                  msg_header_v_o,
    input  logic [num_sink_p-1:0]                  msg_header_ready_and_i,
    output logic [num_sink_p-1:0]                  msg_has_data_o,
    output logic [num_sink_p*data_width_p-1:0]     msg_data_o,
    output logic [num_sink_p-1:0]                  msg_data_v_o,
    input  logic [num_sink_p-1:0]                  msg_data_ready_and_i,
    output logic [num_sink_p-1:0]                  msg_last_o,
    output logic [num_sink_p-1:0]                  burst_overflow_o
);

    localparam int src_w_lp = (num_source_p > 1) ? $clog2(num_source_p) : 1;
    localparam int sum_w_lp = src_w_lp + 1;
    localparam int cnt_w_lp = $clog2(max_beats_p + 1);

    typedef logic [src_w_lp-1:0] src_idx_t;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_OFFER = 2'd1, ST_DATA = 2'd2} state_e;

    state_e                  state_r      [num_sink_p];
    state_e                  state_n_s    [num_sink_p];
    src_idx_t                win_r        [num_sink_p];
    src_idx_t                win_n_s      [num_sink_p];
    src_idx_t                rr_ptr_r     [num_sink_p];
    src_idx_t                rr_ptr_n_s   [num_sink_p];
    src_idx_t                arb_s        [num_sink_p];
    src_idx_t                sel_s        [num_sink_p];
    logic [cnt_w_lp-1:0]     beat_cnt_r   [num_sink_p];
    logic [cnt_w_lp-1:0]     beat_cnt_n_s [num_sink_p];
    logic [num_source_p-1:0] cand_s       [num_sink_p];
    logic [num_sink_p-1:0]   ovf_r, ovf_n_s, cand_any_s, hdr_v_s, hdr_fire_s, dat_v_s, dat_fire_s;
    logic [num_source_p-1:0] busy_r, busy_n_s, busy_set_s, busy_clr_s;

    // Successor of a source index, wrapping modulo num_source_p.
    function automatic src_idx_t next_src(input src_idx_t s);
        return (s == src_idx_t'(num_source_p - 1)) ? src_idx_t'(0) : s + src_idx_t'(1);
    endfunction

    // Per-sink candidate set and winner. The candidate vector is rotated by
    // rr_ptr_r so the lowest set bit is the first candidate at/after the
    // pointer; with rr_p=0 the pointer never moves, giving fixed priority.
    always_comb begin
        logic [2*num_source_p-1:0] dbl_v;
        logic [num_source_p-1:0]   rot_v;
        src_idx_t                  pos_v;
        logic [sum_w_lp-1:0]       sum_v;
        dbl_v = '0;
        rot_v = '0;
        pos_v = '0;
        sum_v = '0;
        for (int j = 0; j < num_sink_p; j++) begin
            for (int i = 0; i < num_source_p; i++) begin
                cand_s[j][i] = msg_header_v_i[i] & ~busy_r[i]
                             & (msg_dst_i[i*lg_num_sink_lp +: lg_num_sink_lp] == lg_num_sink_lp'(j));
            end
            cand_any_s[j] = |cand_s[j];
            dbl_v = {cand_s[j], cand_s[j]};
            rot_v = num_source_p'(dbl_v >> rr_ptr_r[j]);
            pos_v = '0;
            for (int k = num_source_p - 1; k >= 0; k--) begin
                pos_v = rot_v[k] ? src_idx_t'(k) : pos_v;
            end
            sum_v = {1'b0, rr_ptr_r[j]} + {1'b0, pos_v};
            arb_s[j] = (sum_v >= sum_w_lp'(num_source_p))
                     ? src_idx_t'(sum_v - sum_w_lp'(num_source_p)) : src_idx_t'(sum_v);
        end
    end

    // Sink-side muxes, channel valids and source-side ready routing. Valids
    // and readies are forced low while reset is asserted.
    always_comb begin
        logic sel_hit_v, win_hit_v, sel_hv_v, win_dv_v;
        sel_hit_v = 1'b0;
        win_hit_v = 1'b0;
        sel_hv_v  = 1'b0;
        win_dv_v  = 1'b0;
        msg_header_o           = '0;
        msg_has_data_o         = '0;
        msg_data_o             = '0;
        msg_last_o             = '0;
        msg_header_v_o         = '0;
        msg_data_v_o           = '0;
        msg_header_ready_and_o = '0;
        msg_data_ready_and_o   = '0;
        for (int j = 0; j < num_sink_p; j++) begin
            // In IDLE the live arbiter result drives the sink; otherwise the
            // latched winner does, so an offered header cannot change.
            sel_s[j] = (state_r[j] == ST_IDLE) ? arb_s[j] : win_r[j];
            sel_hv_v = 1'b0;
            win_dv_v = 1'b0;
            for (int i = 0; i < num_source_p; i++) begin
                sel_hit_v = (sel_s[j] == src_idx_t'(i));
                win_hit_v = (win_r[j] == src_idx_t'(i));
                msg_header_o[j*header_width_p +: header_width_p] |=
                    {header_width_p{sel_hit_v}} & msg_header_i[i*header_width_p +: header_width_p];
                msg_has_data_o[j] |= sel_hit_v & msg_has_data_i[i];
                sel_hv_v          |= sel_hit_v & msg_header_v_i[i];
                msg_data_o[j*data_width_p +: data_width_p] |=
                    {data_width_p{win_hit_v}} & msg_data_i[i*data_width_p +: data_width_p];
                msg_last_o[j] |= win_hit_v & msg_last_i[i];
                win_dv_v      |= win_hit_v & msg_data_v_i[i];
            end
            case (state_r[j])
                ST_IDLE: begin
                    hdr_v_s[j] = cand_any_s[j];
                    dat_v_s[j] = 1'b0;
                end
                ST_OFFER: begin
                    hdr_v_s[j] = sel_hv_v;
                    dat_v_s[j] = 1'b0;
                end
                ST_DATA: begin
                    hdr_v_s[j] = 1'b0;
                    dat_v_s[j] = win_dv_v;
                end
                default: begin
                    hdr_v_s[j] = 1'b0;
                    dat_v_s[j] = 1'b0;
                end
            endcase
            hdr_v_s[j]    = hdr_v_s[j] & reset_n_i;
            dat_v_s[j]    = dat_v_s[j] & reset_n_i;
            hdr_fire_s[j] = hdr_v_s[j] & msg_header_ready_and_i[j];
            dat_fire_s[j] = dat_v_s[j] & msg_data_ready_and_i[j];
            msg_header_v_o[j] = hdr_v_s[j];
            msg_data_v_o[j]   = dat_v_s[j];
            for (int i = 0; i < num_source_p; i++) begin
                msg_header_ready_and_o[i] |= hdr_v_s[j] & (sel_s[j] == src_idx_t'(i))
                                           & msg_header_ready_and_i[j];
                msg_data_ready_and_o[i]   |= reset_n_i & (state_r[j] == ST_DATA)
                                           & (win_r[j] == src_idx_t'(i)) & msg_data_ready_and_i[j];
            end
        end
    end

    // Next-state logic for each sink's lock FSM, pointer, beat counter and
    // overflow flag, plus the source busy set/clear masks.
    always_comb begin
        busy_set_s = '0;
        busy_clr_s = '0;
        for (int j = 0; j < num_sink_p; j++) begin
            state_n_s[j]    = state_r[j];
            win_n_s[j]      = win_r[j];
            rr_ptr_n_s[j]   = rr_ptr_r[j];
            beat_cnt_n_s[j] = beat_cnt_r[j];
            ovf_n_s[j]      = ovf_r[j];
            case (state_r[j])
                ST_IDLE, ST_OFFER: begin
                    win_n_s[j] = sel_s[j];
                    if (hdr_fire_s[j]) begin
                        state_n_s[j]  = msg_has_data_o[j] ? ST_DATA : ST_IDLE;
                        rr_ptr_n_s[j] = (rr_p != 0) ? next_src(sel_s[j]) : rr_ptr_r[j];
                        for (int i = 0; i < num_source_p; i++) begin
                            busy_set_s[i] |= msg_has_data_o[j] & (sel_s[j] == src_idx_t'(i));
                        end
                    end else begin
                        state_n_s[j] = hdr_v_s[j] ? ST_OFFER : state_r[j];
                    end
                end
                ST_DATA: begin
                    if (dat_fire_s[j]) begin
                        ovf_n_s[j] = ovf_r[j] | (beat_cnt_r[j] == cnt_w_lp'(max_beats_p));
                        if (msg_last_o[j]) begin
                            state_n_s[j]    = ST_IDLE;
                            beat_cnt_n_s[j] = '0;
                            for (int i = 0; i < num_source_p; i++) begin
                                busy_clr_s[i] |= (win_r[j] == src_idx_t'(i));
                            end
                        end else begin
                            // Saturate so the overflow compare stays true for
                            // every further beat of a runaway burst.
                            beat_cnt_n_s[j] = (beat_cnt_r[j] == cnt_w_lp'(max_beats_p))
                                            ? beat_cnt_r[j] : beat_cnt_r[j] + cnt_w_lp'(1);
                        end
                    end else begin
                        state_n_s[j] = ST_DATA;
                    end
                end
                default: begin
                    state_n_s[j] = ST_IDLE;
                end
            endcase
        end
        busy_n_s = (busy_r | busy_set_s) & ~busy_clr_s;
    end

    // State registers; reset abandons any burst in flight.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int j = 0; j < num_sink_p; j++) begin
                state_r[j]    <= ST_IDLE;
                win_r[j]      <= '0;
                rr_ptr_r[j]   <= '0;
                beat_cnt_r[j] <= '0;
            end
            ovf_r  <= '0;
            busy_r <= '0;
        end else begin
            for (int j = 0; j < num_sink_p; j++) begin
                state_r[j]    <= state_n_s[j];
                win_r[j]      <= win_n_s[j];
                rr_ptr_r[j]   <= rr_ptr_n_s[j];
                beat_cnt_r[j] <= beat_cnt_n_s[j];
            end
            ovf_r  <= ovf_n_s;
            busy_r <= busy_n_s;
        end
    end

    assign burst_overflow_o = ovf_r;

endmodule
